// File: rtl/lsu_mo.sv
// Multi-outstanding load/store unit: issues EX1 memory ops to the MMU and
// retires results in order from a DEPTH-entry completion queue.
package lsu_mo_pkg;
    typedef struct packed {
        logic store;
        logic size_byte;
        logic size_half;
        logic size_word;
        logic load_sign;
    } mem_opcode_t;

    typedef enum logic [2:0] {
        EXCP_NONE   = 3'd0,
        EXCP_ALE    = 3'd1,
        EXCP_D_TLBR = 3'd2,
        EXCP_PIL    = 3'd3,
        EXCP_PIS    = 3'd4,
        EXCP_PPI    = 3'd5,
        EXCP_PME    = 3'd6
    } excp_t;
endpackage

module lsu_mo
    import lsu_mo_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter bit BYPASS = 1'b1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        cancel,
    input  logic        valid,
    input  logic [31:0] addr,
    input  mem_opcode_t opcode,
    input  logic [31:0] st_data,
    output logic        ready,
    output logic        have_excp,
    output excp_t       excp_type,
    output logic        idle,
    output logic        ok,
    output logic [31:0] ld_data,
    input  logic        accept_ok,
    output logic        mmu_req,
    output logic [31:0] mmu_addr,
    output logic        mmu_we,
    output logic [1:0]  mmu_size,
    output logic [3:0]  mmu_wstrb,
    output logic [31:0] mmu_wdata,
    input  logic        mmu_addr_ok,
    input  logic        mmu_data_ok,
    input  logic [31:0] mmu_rdata,
    input  logic        mmu_tlbr,
    input  logic        mmu_pil,
    input  logic        mmu_pis,
    input  logic        mmu_ppi,
    input  logic        mmu_pme
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int PW = AW + 1;

    function automatic logic [31:0] fmt_load(input logic [31:0] d, input logic [1:0] lo,
                                             input logic [1:0] size, input logic sgn,
                                             input logic st);
        logic signed [7:0]  b;
        logic signed [15:0] h;
        logic [31:0]        r;
        b = d[{lo, 3'b000} +: 8];
        h = lo[1] ? d[31:16] : d[15:0];
        case (size)
            2'd0:    r = sgn ? {{24{b[7]}}, b} : {24'b0, b};
            2'd1:    r = sgn ? {{16{h[15]}}, h} : {16'b0, h};
            default: r = d;
        endcase
        if (st) r = '0;
        return r;
    endfunction

    logic [PW-1:0] alloc_ptr, fill_ptr, head_ptr, count;
    logic [AW-1:0] alloc_idx, fill_idx, head_idx;
    logic [1:0]    e_lo    [DEPTH];
    logic [1:0]    e_size  [DEPTH];
    logic          e_sign  [DEPTH];
    logic          e_store [DEPTH];
    logic [31:0]   e_data  [DEPTH];
    logic [DEPTH-1:0] e_done, e_killed;

    logic        full, push, fill_en, head_live, head_fill;
    logic        ok_reg, ok_byp, retire;
    logic [31:0] fill_data;

    assign alloc_idx = alloc_ptr[AW-1:0];
    assign fill_idx  = fill_ptr[AW-1:0];
    assign head_idx  = head_ptr[AW-1:0];

    always_comb begin
        have_excp = 1'b0;
        excp_type = EXCP_NONE;
        if (valid) begin
            have_excp = 1'b1;
            if ((opcode.size_half && addr[0]) || (opcode.size_word && addr[1:0] != 2'b00))
                excp_type = EXCP_ALE;
            else if (mmu_tlbr) excp_type = EXCP_D_TLBR;
            else if (mmu_pil)  excp_type = EXCP_PIL;
            else if (mmu_pis)  excp_type = EXCP_PIS;
            else if (mmu_ppi)  excp_type = EXCP_PPI;
            else if (mmu_pme)  excp_type = EXCP_PME;
            else               have_excp = 1'b0;
        end
    end

    assign full      = (count == PW'(DEPTH));
    assign mmu_req   = valid && !have_excp && !cancel && !full;
    assign push      = mmu_req && mmu_addr_ok;
    assign ready     = (!full && (!valid || have_excp || mmu_addr_ok)) || (valid && cancel);
    assign mmu_addr  = addr;
    assign mmu_we    = opcode.store;
    assign mmu_size  = {opcode.size_word, opcode.size_half};
    assign idle      = (count == '0);

    always_comb begin
        mmu_wstrb = 4'b0000;
        mmu_wdata = st_data;
        if (opcode.size_word) begin
            mmu_wstrb = 4'b1111;
        end else if (opcode.size_half) begin
            mmu_wstrb = addr[1] ? 4'b1100 : 4'b0011;
            mmu_wdata = {2{st_data[15:0]}};
        end else if (opcode.size_byte) begin
            mmu_wstrb = 4'b0001 << addr[1:0];
            mmu_wdata = {4{st_data[7:0]}};
        end
    end

    // A data_ok with nothing outstanding (fill caught up with alloc) is dropped.
    assign fill_en   = mmu_data_ok && (fill_ptr != alloc_ptr);
    assign fill_data = fmt_load(mmu_rdata, e_lo[fill_idx], e_size[fill_idx],
                                e_sign[fill_idx], e_store[fill_idx]);
    assign head_live = !idle;
    assign head_fill = fill_en && (fill_ptr == head_ptr);
    assign ok_reg    = head_live && e_done[head_idx] && !e_killed[head_idx] && !cancel;
    assign ok_byp    = BYPASS && head_fill && !e_killed[head_idx] && !cancel;
    assign ok        = ok_reg || ok_byp;
    assign ld_data   = ok_reg ? e_data[head_idx] : (ok_byp ? fill_data : 32'h0);
    assign retire    = (ok && accept_ok) || (head_live && e_done[head_idx] && e_killed[head_idx]);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            alloc_ptr <= '0;
            fill_ptr  <= '0;
            head_ptr  <= '0;
            count     <= '0;
            e_done    <= '0;
            e_killed  <= '0;
        end else begin
            if (push)    alloc_ptr <= alloc_ptr + PW'(1);
            if (fill_en) fill_ptr  <= fill_ptr + PW'(1);
            if (retire)  head_ptr  <= head_ptr + PW'(1);
            count <= count + PW'(push) - PW'(retire);
            for (int i = 0; i < DEPTH; i++) begin
                if (push && alloc_idx == AW'(i)) begin
                    e_done[i]   <= 1'b0;
                    e_killed[i] <= 1'b0;
                end else begin
                    if (fill_en && fill_idx == AW'(i)) e_done[i] <= 1'b1;
                    if (cancel) e_killed[i] <= 1'b1;
                end
            end
        end
    end

    // Payload storage carries no reset; done/killed gate every use of it.
    always_ff @(posedge clk) begin
        if (push) begin
            e_lo[alloc_idx]    <= addr[1:0];
            e_size[alloc_idx]  <= mmu_size;
            e_sign[alloc_idx]  <= opcode.load_sign;
            e_store[alloc_idx] <= opcode.store;
        end
        if (fill_en) e_data[fill_idx] <= fill_data;
    end
endmodule
